// File: rtl/cam_capture_pkg.sv
// Shared types and widths for the camera capture writer.
package cam_capture_pkg;

    localparam int PIXEL_W    = 16;
    localparam int CAM_BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cam_state_e;

endpackage

// File: rtl/cam_sync_edge.sv
// Two-flop synchronizer for one asynchronous camera line, with a third flop
// for rising/falling edge detection in the clk_i domain.
module cam_sync_edge (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sync_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], async_i};
        end
    end

    assign rise_o = sync_q[1] & ~sync_q[2];
    assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/cam_capture_writer.sv
// Captures RGB565 frames from a byte-wide camera into a frame-buffer write port.
// Define CAM_CAPTURE_TEST_PATTERN_EN to replace camera pixels with a position pattern.
module cam_capture_writer
    import cam_capture_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int H_PIXELS   = 320,
    parameter int V_LINES    = 240
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  start_i,
    input  logic                  continuous_i,
    input  logic                  cam_pclk_i,
    input  logic                  cam_vsync_i,
    input  logic                  cam_href_i,
    input  logic [CAM_BYTE_W-1:0] cam_data_i,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [PIXEL_W-1:0]    wr_data_o,
    output logic                  wr_en_o,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic                  overflow_o,
    output logic [ADDR_WIDTH:0]   pixel_count_o
);

    localparam int                FRAME_PIXELS   = H_PIXELS * V_LINES;
    localparam logic [ADDR_WIDTH:0] FRAME_PIXELS_C = FRAME_PIXELS[ADDR_WIDTH:0];

    cam_state_e state_q, state_d;

    logic                  pclk_rise, pclk_fall_unused;
    logic                  vsync_rise, vsync_fall;
    logic [1:0]            href_sync_q;
    logic                  href_s;
    logic                  phase_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [PIXEL_W-1:0]    wr_data_q, pixel_d;
    logic                  wr_en_q, overflow_q;
    logic                  capture_start, byte_edge, low_byte_edge;

    cam_sync_edge u_pclk_sync (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .async_i   (cam_pclk_i),
        .rise_o    (pclk_rise),
        .fall_o    (pclk_fall_unused)
    );

    cam_sync_edge u_vsync_sync (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .async_i   (cam_vsync_i),
        .rise_o    (vsync_rise),
        .fall_o    (vsync_fall)
    );

    // href travels through the same two-flop depth as pclk so they stay aligned.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            href_sync_q <= 2'b00;
        end else begin
            href_sync_q <= {href_sync_q[0], cam_href_i};
        end
    end

    assign href_s        = href_sync_q[1];
    assign capture_start = (state_q == ST_ARM) && vsync_fall;
    assign byte_edge     = (state_q == ST_CAPTURE) && href_s && pclk_rise;
    assign low_byte_edge = byte_edge && phase_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start_i)    state_d = ST_ARM;
            ST_ARM:     if (vsync_fall) state_d = ST_CAPTURE;
            ST_CAPTURE: if (vsync_rise) state_d = ST_DONE;
            ST_DONE:    state_d = continuous_i ? ST_ARM : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

`ifdef CAM_CAPTURE_TEST_PATTERN_EN
    localparam int POS_W = (ADDR_WIDTH > 6) ? ADDR_WIDTH : 6;
    localparam logic [POS_W-1:0] LAST_COL = POS_W'(H_PIXELS - 1);

    logic [POS_W-1:0] col_q, line_q;

    // Position tracks the pixel index of the next write, advancing with each strobe.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            col_q  <= '0;
            line_q <= '0;
        end else begin
            if (wr_en_q) begin
                if (col_q == LAST_COL) begin
                    col_q  <= '0;
                    line_q <= line_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
            if (capture_start) begin
                col_q  <= '0;
                line_q <= '0;
            end
        end
    end

    assign pixel_d = {col_q[4:0], line_q[5:0], col_q[4:0]};
`else
    logic [CAM_BYTE_W-1:0] data_s1_q, data_s2_q, high_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_s1_q <= '0;
            data_s2_q <= '0;
            high_q    <= '0;
        end else begin
            data_s1_q <= cam_data_i;
            data_s2_q <= data_s1_q;
            if (byte_edge && !phase_q) begin
                high_q <= data_s2_q;
            end
        end
    end

    assign pixel_d = {high_q, data_s2_q};
`endif

    // A write strobe lands one cycle after the low-byte edge; the address and
    // count advance on the cycle after that strobe.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            phase_q    <= 1'b0;
            addr_q     <= '0;
            count_q    <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            if (wr_en_q) begin
                addr_q  <= addr_q + 1'b1;
                count_q <= count_q + 1'b1;
            end
            if ((state_q == ST_IDLE) && start_i) begin
                overflow_q <= 1'b0;
            end
            if (capture_start) begin
                phase_q <= 1'b0;
                addr_q  <= '0;
                count_q <= '0;
            end else if (state_q == ST_CAPTURE) begin
                if (!href_s) begin
                    phase_q <= 1'b0;
                end else if (pclk_rise) begin
                    phase_q <= ~phase_q;
                end
                if (low_byte_edge) begin
                    if (count_q < FRAME_PIXELS_C) begin
                        wr_en_q   <= 1'b1;
                        wr_data_q <= pixel_d;
                    end else begin
                        overflow_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign wr_addr_o     = addr_q;
    assign wr_data_o     = wr_data_q;
    assign wr_en_o       = wr_en_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign frame_done_o  = (state_q == ST_DONE);
    assign overflow_o    = overflow_q;
    assign pixel_count_o = count_q;

endmodule

// File: tb/tb_cam_capture_writer.sv
// Randomized bench for cam_capture_writer on a 4x2 frame, with a pixel-level reference model.
module tb_cam_capture_writer;

    localparam int AW    = 3;
    localparam int H     = 4;
    localparam int V     = 2;
    localparam int FRAME = H * V;

    logic          clk = 1'b0;
    logic          reset_n_i = 1'b0;
    logic          start_i = 1'b0;
    logic          continuous_i = 1'b0;
    logic          cam_pclk_i = 1'b0;
    logic          cam_vsync_i = 1'b0;
    logic          cam_href_i = 1'b0;
    logic [7:0]    cam_data_i = 8'h00;
    logic [AW-1:0] wr_addr_o;
    logic [15:0]   wr_data_o;
    logic          wr_en_o;
    logic          busy_o;
    logic          frame_done_o;
    logic          overflow_o;
    logic [AW:0]   pixel_count_o;

    always #5 clk = ~clk;

    cam_capture_writer #(
        .ADDR_WIDTH (AW),
        .H_PIXELS   (H),
        .V_LINES    (V)
    ) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n_i),
        .start_i       (start_i),
        .continuous_i  (continuous_i),
        .cam_pclk_i    (cam_pclk_i),
        .cam_vsync_i   (cam_vsync_i),
        .cam_href_i    (cam_href_i),
        .cam_data_i    (cam_data_i),
        .wr_addr_o     (wr_addr_o),
        .wr_data_o     (wr_data_o),
        .wr_en_o       (wr_en_o),
        .busy_o        (busy_o),
        .frame_done_o  (frame_done_o),
        .overflow_o    (overflow_o),
        .pixel_count_o (pixel_count_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: expected writes as {addr, data}.
    logic [AW+15:0] exp_q[$];
    int             m_count = 0;
    bit             m_ovf = 1'b0;
    int             exp_done = 0;
    int             done_cnt = 0;
    int             busy_low = 0;
    bit             watch_busy = 1'b0;
    bit             dir_mode = 1'b0;
    logic [7:0]     dir_val = 8'h12;
    int             lens[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en_o) begin
            if (exp_q.size() == 0) check("wr_extra", exp_q.size(), 1);
            else check("wr", {wr_addr_o, wr_data_o}, exp_q.pop_front());
        end
        if (frame_done_o) done_cnt++;
        if (watch_busy && !busy_o) busy_low++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic get_byte(output logic [7:0] b);
        if (dir_mode) begin
            b = dir_val;
            dir_val = dir_val + 8'h22;
        end else begin
            b = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        cam_data_i = b;
        wait_clk(2);
        cam_pclk_i = 1'b1;
        wait_clk(4);
        cam_pclk_i = 1'b0;
        wait_clk(2);
    endtask

    // Bytes pair up high-then-low within a line; a pixel is kept only while
    // the frame still has room, otherwise it marks overflow.
    task automatic send_line(input int n, input bit live, input bit end_line);
        logic [7:0]    b, hi;
        logic [AW-1:0] a;
        hi = 8'h00;
        cam_href_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            get_byte(b);
            if (i % 2 == 0) begin
                hi = b;
            end else if (live) begin
                if (m_count < FRAME) begin
                    a = m_count[AW-1:0];
                    exp_q.push_back({a, hi, b});
                    m_count++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            send_byte(b);
        end
        if (end_line) begin
            cam_href_i = 1'b0;
            wait_clk(4);
        end
    endtask

    task automatic do_start(input bit accepted);
        start_i = 1'b1;
        wait_clk(1);
        start_i = 1'b0;
        if (accepted) m_ovf = 1'b0;
        wait_clk(1);
    endtask

    task automatic run_frame(input bit live, input int start_at);
        cam_vsync_i = 1'b1;
        wait_clk(6);
        cam_vsync_i = 1'b0;
        if (live) m_count = 0;
        wait_clk(6);
        for (int i = 0; i < lens.size(); i++) begin
            if (i == start_at) do_start(1'b0);
            send_line(lens[i], live, 1'b1);
        end
        cam_vsync_i = 1'b1;
        wait_clk(8);
        if (live) exp_done++;
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_drain"}, exp_q.size(), 0);
        check({tag, "_done"}, done_cnt, exp_done);
        check({tag, "_pixcnt"}, pixel_count_o, m_count);
        check({tag, "_ovf"}, overflow_o, m_ovf);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"}, wr_addr_o, 0);
        check({tag, "_data"}, wr_data_o, 0);
        check({tag, "_wren"}, wr_en_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, frame_done_o, 0);
        check({tag, "_ovf"}, overflow_o, 0);
        check({tag, "_pixcnt"}, pixel_count_o, 0);
    endtask

    initial begin
        wait_clk(3);
        check_all_zero("reset");
        reset_n_i = 1'b1;
        wait_clk(3);

        // Directed frame with the 0x12,0x34,... byte sequence.
        dir_mode = 1'b1;
        dir_val  = 8'h12;
        lens     = '{8, 8};
        do_start(1'b1);
        check("arm_busy", busy_o, 1);
        run_frame(1'b1, -1);
        check_frame("basic");
        check("idle_busy", busy_o, 0);

        // Ten pixels into an eight-pixel frame; a start pulse mid-capture is ignored.
        lens = '{8, 8, 4};
        do_start(1'b1);
        run_frame(1'b1, 2);
        check_frame("ovf");
        wait_clk(20);
        check("ovf_sticky", overflow_o, m_ovf);
        do_start(1'b1);
        check("ovf_clear", overflow_o, m_ovf);

        // Odd-length line drops its trailing byte; the next line starts on a high byte.
        dir_mode = 1'b0;
        lens = '{3, 2, 5};
        run_frame(1'b1, -1);
        check_frame("odd");

        // Continuous mode re-arms; addresses restart each frame.
        continuous_i = 1'b1;
        lens = '{8, 8};
        do_start(1'b1);
        watch_busy = 1'b1;
        run_frame(1'b1, -1);
        check_frame("cont1");
        run_frame(1'b1, -1);
        check_frame("cont2");
        wait_clk(5);
        watch_busy = 1'b0;
        continuous_i = 1'b0;
        run_frame(1'b1, -1);
        check_frame("cont3");
        check("cont_busy", busy_low, 0);
        check("cont_idle", busy_o, 0);

        // Reset in the middle of a line after three pixels.
        do_start(1'b1);
        cam_vsync_i = 1'b1;
        wait_clk(6);
        cam_vsync_i = 1'b0;
        m_count = 0;
        wait_clk(6);
        send_line(7, 1'b1, 1'b0);
        check("mid_pixcnt", pixel_count_o, m_count);
        reset_n_i = 1'b0;
        #1;
        check_all_zero("midrst");
        m_count = 0;
        m_ovf = 1'b0;
        cam_href_i = 1'b0;
        wait_clk(3);
        reset_n_i = 1'b1;
        wait_clk(3);
        lens = '{8, 8};
        run_frame(1'b0, -1);
        check_frame("norestart");
        check("norestart_busy", busy_o, 0);
        do_start(1'b1);
        run_frame(1'b1, -1);
        check_frame("restart");

        // Random frames with random line lengths and pixel data.
        for (int f = 0; f < 6; f++) begin
            lens = {};
            for (int l = 0; l < int'($urandom_range(1, 3)); l++) begin
                lens.push_back(int'($urandom_range(0, 9)));
            end
            do_start(1'b1);
            run_frame(1'b1, -1);
            check_frame("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout got 0 exp 1");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
